// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Byte-serial memory controller / arbiter between the IF stage,
//            the MEM stage and a single 8-bit RAM port. Assembles and
//            disassembles 32-bit little-endian words and raises the MEM
//            stall request while a MEM access is outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy,
  // instruction fetch side
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  // load/store side
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_len_i,
  input  logic              mem_signed_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  // stall request towards the staller
  output logic [1:0]        rq_MEM_o,
  // RAM port
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  localparam logic [1:0] c_RQ_NONE       = 2'b00;
  localparam logic [1:0] c_RQ_MEM_ACCESS = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IF_BUSY  = 2'd1,
    S_MEM_BUSY = 2'd2
  } state_t;

  // Pick byte k out of a little-endian word.
  function automatic logic [7:0] f_byte(input logic [31:0] d, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  // Return word d with byte k replaced by b.
  function automatic logic [31:0] f_put(input logic [31:0] d, input logic [1:0] k,
                                        input logic [7:0] b);
    logic [31:0] r;
    r = d;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Index of the last byte of an access: byte -> 0, half -> 1, word (or 11) -> 3.
  function automatic logic [1:0] f_last(input logic [1:0] len);
    logic [1:0] l;
    case (len)
      2'b00:   l = 2'd0;
      2'b01:   l = 2'd1;
      default: l = 2'd3;
    endcase
    return l;
  endfunction

  // FSM and captured operands
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_last;
  logic              r_we;
  logic              r_signed;
  logic [31:0]       r_wdata;

  // Read pipeline: "a" is the byte address driven this cycle, "d" is the
  // byte whose data is on mem_din this cycle (address driven last cycle).
  logic [1:0]        r_a_idx;
  logic              r_a_valid;
  logic [1:0]        r_d_idx;
  logic              r_d_valid;
  logic [31:0]       r_buf;

  // Registered RAM port and result outputs
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_dout;
  logic              r_wr;
  logic [31:0]       r_if_data;
  logic              r_if_done;
  logic [31:0]       r_mem_rdata;
  logic              r_mem_done;

  // Combinational controls
  logic              w_arb_ok;
  logic              w_acc_mem;
  logic              w_acc_if;
  logic              w_rd_phase;
  logic              w_wr_phase;
  logic              w_capture;
  logic              w_rd_finish;
  logic              w_wr_finish;
  logic [1:0]        w_a_idx_inc;
  logic [ADDR_W-1:0] w_a_next;
  logic [31:0]       w_asm;
  logic [31:0]       w_ext;

  // Requests are only looked at when the port is running and no done pulse
  // is on the outputs, so a finishing requester cannot be re-accepted.
  assign w_arb_ok    = rdy && !r_if_done && !r_mem_done;
  assign w_rd_phase  = (r_state == S_IF_BUSY) || ((r_state == S_MEM_BUSY) && !r_we);
  assign w_wr_phase  = (r_state == S_MEM_BUSY) && r_we;
  assign w_capture   = w_rd_phase && rdy && r_d_valid;
  assign w_rd_finish = w_capture && (r_d_idx == r_last);
  assign w_wr_finish = w_wr_phase && rdy && (r_a_idx == r_last);
  assign w_a_idx_inc = r_a_idx + 2'd1;
  assign w_a_next    = r_base + ADDR_W'(w_a_idx_inc);

  // Next-state and accept decisions; MEM wins over IF, no preemption.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_mem   = 1'b0;
    w_acc_if    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_ok) begin
          if (mem_req_i) begin
            w_acc_mem   = 1'b1;
            w_state_nxt = S_MEM_BUSY;
          end else if (if_req_i) begin
            w_acc_if    = 1'b1;
            w_state_nxt = S_IF_BUSY;
          end
        end
      end
      S_IF_BUSY: begin
        if (w_rd_finish) w_state_nxt = S_IDLE;
      end
      S_MEM_BUSY: begin
        if (w_rd_finish || w_wr_finish) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Merge the byte arriving on mem_din into the partially assembled word,
  // then extend narrow loads.
  always_comb begin
    w_asm = f_put(r_buf, r_d_idx, mem_din);
    case (r_last)
      2'd0:    w_ext = {{24{r_signed & w_asm[7]}},  w_asm[7:0]};
      2'd1:    w_ext = {{16{r_signed & w_asm[15]}}, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Datapath: operand capture, address sequencing, byte assembly, results.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_base      <= '0;
      r_last      <= 2'd0;
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_wdata     <= 32'h0;
      r_a_idx     <= 2'd0;
      r_a_valid   <= 1'b0;
      r_d_idx     <= 2'd0;
      r_d_valid   <= 1'b0;
      r_buf       <= 32'h0;
      r_mem_a     <= IDLE_ADDR;
      r_dout      <= 8'h00;
      r_wr        <= 1'b0;
      r_if_data   <= 32'h0;
      r_if_done   <= 1'b0;
      r_mem_rdata <= 32'h0;
      r_mem_done  <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      if (w_acc_mem || w_acc_if) begin
        // Accept: latch all operands; byte 0 goes out in the next cycle.
        r_base    <= w_acc_mem ? mem_addr_i : if_addr_i;
        r_mem_a   <= w_acc_mem ? mem_addr_i : if_addr_i;
        r_last    <= w_acc_mem ? f_last(mem_len_i) : 2'd3;
        r_we      <= w_acc_mem && mem_we_i;
        r_signed  <= w_acc_mem && mem_signed_i;
        r_wdata   <= mem_wdata_i;
        r_wr      <= w_acc_mem && mem_we_i;
        r_dout    <= (w_acc_mem && mem_we_i) ? mem_wdata_i[7:0] : 8'h00;
        r_a_idx   <= 2'd0;
        r_a_valid <= 1'b1;
        r_d_idx   <= 2'd0;
        r_d_valid <= 1'b0;
        r_buf     <= 32'h0;
      end else if (w_rd_phase) begin
        if (rdy) begin
          if (r_d_valid) r_buf <= w_asm;
          if (w_rd_finish) begin
            r_a_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_mem_a   <= IDLE_ADDR;
            if (r_state == S_IF_BUSY) begin
              r_if_data <= w_asm;
              r_if_done <= 1'b1;
            end else begin
              r_mem_rdata <= w_ext;
              r_mem_done  <= 1'b1;
            end
          end else begin
            r_d_valid <= r_a_valid;
            r_d_idx   <= r_a_idx;
            if (r_a_valid && (r_a_idx != r_last)) begin
              r_a_idx <= w_a_idx_inc;
              r_mem_a <= w_a_next;
            end else begin
              r_a_valid <= 1'b0;
              r_mem_a   <= IDLE_ADDR;
            end
          end
        end else if (r_d_valid) begin
          // The byte on mem_din is about to be lost: step back and
          // re-drive its address so it returns again after the pause.
          r_a_idx   <= r_d_idx;
          r_a_valid <= 1'b1;
          r_mem_a   <= r_base + ADDR_W'(r_d_idx);
          r_d_valid <= 1'b0;
        end
      end else if (w_wr_phase && rdy) begin
        if (w_wr_finish) begin
          r_wr       <= 1'b0;
          r_dout     <= 8'h00;
          r_mem_a    <= IDLE_ADDR;
          r_mem_done <= 1'b1;
        end else begin
          r_a_idx <= w_a_idx_inc;
          r_mem_a <= w_a_next;
          r_dout  <= f_byte(r_wdata, w_a_idx_inc);
        end
      end
    end
  end

  // Outputs; the write strobe is gated so nothing is written while paused.
  assign mem_a       = r_mem_a;
  assign mem_dout    = r_dout;
  assign mem_wr      = r_wr && rdy;
  assign if_data_o   = r_if_data;
  assign if_done_o   = r_if_done;
  assign mem_rdata_o = r_mem_rdata;
  assign mem_done_o  = r_mem_done;
  assign rq_MEM_o    = (mem_req_i && !r_mem_done) ? c_RQ_MEM_ACCESS : c_RQ_NONE;

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller and arbiter between the IF stage (instruction fetch) and the MEM stage (loads/stores) and the single 8-bit RAM port.
- Assembles and disassembles 32-bit little-endian words.
- Drives the stall-request code consumed by the pipeline staller (`rq_MEM_o`) while a MEM access is outstanding.
- Sits directly upstream of the staller; the staller turns `rq_MEM_o` into stall controls for IF, IF/ID, ID/EX and EX/MEM.

Parameters:
ADDR_W, 32, byte-address width
IDLE_ADDR, 32'h0, value driven on mem_a when no transaction is active

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous reset, active-low (0 = reset)
rdy  input  1  global ready; 0 pauses the block
if_req_i  input  1  IF fetch request, held until if_done_o
if_addr_i  input  ADDR_W  fetch address, stable while if_req_i=1
if_data_o  output  32  fetched instruction, valid when if_done_o=1
if_done_o  output  1  one-cycle completion pulse for IF
mem_req_i  input  1  MEM access request, held until mem_done_o
mem_we_i  input  1  1 = store, 0 = load
mem_addr_i  input  ADDR_W  byte address
mem_len_i  input  2  00 = byte, 01 = half, 10 = word (11 treated as word)
mem_signed_i  input  1  load sign-extends when 1
mem_wdata_i  input  32  store data, low bytes used
mem_rdata_o  output  32  load result, valid when mem_done_o=1
mem_done_o  output  1  one-cycle completion pulse for MEM
rq_MEM_o  output  2  stall request to staller: 2'b01 = MEM_ACCESS, 2'b00 = none
mem_din  input  8  RAM read data, returns the byte for the address of the previous cycle
mem_dout  output  8  RAM write data
mem_a  output  ADDR_W  RAM byte address
mem_wr  output  1  RAM write strobe

Behaviour:
- States: IDLE, IF_BUSY, MEM_BUSY. Byte count N = 4 for IF; 1, 2 or 4 for MEM.
- Reset:
  - state = IDLE, all counters = 0.
  - if_data_o = mem_rdata_o = 0, both done pulses = 0.
  - mem_a = IDLE_ADDR, mem_dout = 0, mem_wr = 0.
  - Reset mid-transaction abandons the transaction silently; no done pulse is produced.
- Arbitration: requests are sampled only in IDLE, and only in cycles where neither done pulse is high.
  - MEM has priority over IF.
  - Non-preemptive: a MEM request arriving during IF_BUSY waits until the IF transaction finishes.
- rq_MEM_o (combinational):
  - 2'b01 whenever mem_req_i=1 and mem_done_o=0, including while the request waits behind an IF transaction.
  - 2'b00 otherwise, including in the done cycle, so the pipeline advances that cycle.
- Read timing (IF, or MEM load), with accept edge E0:
  - Registered address base+k is driven in cycle k (between edges Ek and Ek+1).
  - Byte k is captured from mem_din at edge Ek+2 and placed at bits [8k+7:8k].
  - At edge EN+1 the done output goes high for exactly one cycle, the data output is updated, and state returns to IDLE.
  - A word read has its done pulse in the 6th cycle counted from E0.
- Loads narrower than a word:
  - Unused upper bits = sign of the top byte if mem_signed_i=1, else 0.
  - mem_signed_i is captured at accept.
- Write timing:
  - mem_wr=1 and mem_dout = byte k of mem_wdata_i in cycle k, for k = 0..N-1.
  - mem_done_o pulses in cycle N; mem_wr=0 in that cycle.
- Operand capture: address, length, we, signed and wdata are captured at accept; later input changes are ignored.
- Address wrap: base+k wraps modulo 2^ADDR_W.
- rdy=0:
  - State, counters and assembled data freeze; mem_wr is forced 0; done pulses are held off.
  - A read byte whose data would have been captured during the pause is re-requested by re-driving its address after resume.
  - Result data must equal what an uninterrupted transaction would return.
- No transaction active: mem_a = IDLE_ADDR, mem_wr = 0.
- If IF and MEM both request with MEM winning, IF is served immediately after mem_done_o, in the first eligible IDLE cycle.

Test Plan:
- Word fetch: IF request for 0x1000, with RAM bytes 0x13,0x05,0x10,0x00 → if_done_o in the 6th cycle after accept, if_data_o = 0x00100513, mem_a sequence 0x1000..0x1003.
- Signed byte load: address 0x20 holds 0x80, mem_signed_i=1 → mem_rdata_o = 0xFFFFFF80; repeat with mem_signed_i=0 → 0x00000080; rq_MEM_o = 01 until the done cycle, then 00.
- Half store: 0xBEEF to 0x40 → mem_wr=1 for exactly two cycles with (0x40, 0xEF) then (0x41, 0xBE); mem_done_o in the following cycle.
- Simultaneous IF and MEM word requests in IDLE → MEM served first; IF accepted the cycle after mem_done_o with no lost or repeated bytes; MEM request raised during IF_BUSY → rq_MEM_o = 01 immediately, served after if_done_o.
- rdy held 0 for 3 cycles in the middle of a word load → mem_wr stays 0, result identical to the unpaused run, done pulse delayed by 3 or more cycles.
- rst_in pulled low during a word store → mem_wr=0 and mem_a=IDLE_ADDR immediately (asynchronous); no done pulse; after reset, a new IF request completes normally.
